// File: rtl/vector_ram_arbiter_if.sv
// Bus bundle between the vector LSU, the host/DMA loader and the shared vector data RAM.
// The arbiter takes the slave view; the requesters and RAM side take the master view.
interface vector_ram_arbiter_if;
    // Port A: vector load/store unit
    logic         a_rden;
    logic         a_wren;
    logic         a_lock;
    logic [13:0]  a_address;
    logic [31:0]  a_byteena;
    logic [255:0] a_writeData;
    logic         a_stall;
    logic         a_rvalid;
    logic [255:0] a_readData;

    // Port B: host/DMA loader
    logic         b_req;
    logic         b_we;
    logic [13:0]  b_address;
    logic [31:0]  b_byteena;
    logic [255:0] b_writeData;
    logic         b_gnt;
    logic         b_rvalid;
    logic [255:0] b_readData;

    // RAM side
    logic         rden;
    logic         wren;
    logic [13:0]  ip_address;
    logic [31:0]  byteena;
    logic [255:0] writeData;
    logic [255:0] readData;

    modport slave (
        input  a_rden, a_wren, a_lock, a_address, a_byteena, a_writeData,
        output a_stall, a_rvalid, a_readData,
        input  b_req, b_we, b_address, b_byteena, b_writeData,
        output b_gnt, b_rvalid, b_readData,
        output rden, wren, ip_address, byteena, writeData,
        input  readData
    );

    modport master (
        output a_rden, a_wren, a_lock, a_address, a_byteena, a_writeData,
        input  a_stall, a_rvalid, a_readData,
        output b_req, b_we, b_address, b_byteena, b_writeData,
        input  b_gnt, b_rvalid, b_readData,
        input  rden, wren, ip_address, byteena, writeData,
        output readData
    );
endinterface

// File: rtl/vector_ram_arbiter.sv
// Single-port vector RAM arbiter: LSU has priority, host gets a forced slot after
// STARVE_LIMIT denied cycles, and read data is steered back by a latency-matched tag pipe.
module vector_ram_arbiter #(
    parameter int READ_LATENCY = 1,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    vector_ram_arbiter_if.slave   bus
);

    typedef enum logic {A_PRIO, FORCE_B} state_e;

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    state_e                  state_q, state_d;
    logic [7:0]              wait_cnt_q, wait_cnt_d;
    logic [READ_LATENCY-1:0] tag_vld_q, tag_own_q;

    logic         a_req, grant_a, grant_b, force_b;
    logic         rden_c, wren_c;
    logic [13:0]  addr_c;
    logic [31:0]  be_c;
    logic [255:0] wd_c;

    // Grant decision, starvation counter and next state
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        grant_a    = 1'b0;
        grant_b    = 1'b0;
        state_d    = A_PRIO;
        wait_cnt_d = wait_cnt_q;
        a_req      = bus.a_rden | bus.a_wren;

        // A counter left saturated by an a_lock window forces B as soon as the lock drops.
        force_b = (state_q == FORCE_B) ||
                  (!bus.a_lock && bus.b_req && (wait_cnt_q == LIMIT));

        if (force_b) begin
            grant_b = bus.b_req;
        end else if (bus.a_lock || a_req) begin
            grant_a = a_req;
        end else begin
            grant_b = bus.b_req;
        end

        if (!bus.b_req || grant_b) begin
            wait_cnt_d = 8'd0;
        end else if (wait_cnt_q != LIMIT) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end

        if (!force_b && !bus.a_lock && bus.b_req && (wait_cnt_d == LIMIT)) begin
            state_d = FORCE_B;
        end
    end

    // RAM request mux; everything is held at zero while reset is asserted
    always_comb begin
        rden_c = 1'b0;
        wren_c = 1'b0;
        addr_c = bus.a_address;
        be_c   = '0;
        wd_c   = '0;
        if (reset) begin
            addr_c = '0;
        end else if (grant_a) begin
            rden_c = bus.a_rden & ~bus.a_wren;
            wren_c = bus.a_wren;
            be_c   = bus.a_byteena;
            wd_c   = bus.a_writeData;
        end else if (grant_b) begin
            rden_c = ~bus.b_we;
            wren_c = bus.b_we;
            addr_c = bus.b_address;
            be_c   = bus.b_byteena;
            wd_c   = bus.b_writeData;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= A_PRIO;
            wait_cnt_q <= 8'd0;
            tag_vld_q  <= '0;
            tag_own_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments let each tag stage take the previous stage's old value.
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            tag_vld_q[0] <= rden_c;
            tag_own_q[0] <= grant_b;
            for (int i = 1; i < READ_LATENCY; i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_own_q[i] <= tag_own_q[i-1];
            end
        end
    end

    assign bus.a_stall    = ~reset & a_req & ~grant_a;
    assign bus.b_gnt      = ~reset & grant_b;
    assign bus.rden       = rden_c;
    assign bus.wren       = wren_c;
    assign bus.ip_address = addr_c;
    assign bus.byteena    = be_c;
    assign bus.writeData  = wd_c;

    assign bus.a_rvalid   = ~reset & tag_vld_q[READ_LATENCY-1] & ~tag_own_q[READ_LATENCY-1];
    assign bus.b_rvalid   = ~reset & tag_vld_q[READ_LATENCY-1] &  tag_own_q[READ_LATENCY-1];
    assign bus.a_readData = bus.readData;
    assign bus.b_readData = bus.readData;

endmodule

// File: tb/tb_vector_ram_arbiter.sv
// Directed bench for vector_ram_arbiter: per-cycle checks of grants and the RAM mux,
// plus a scoreboard that matches every returned read against the expected owner and data.
module tb_vector_ram_arbiter;

    localparam int LAT   = 2;
    localparam int LIMIT = 8;

    typedef struct {
        logic         owner;   // 0 = A, 1 = B
        logic [255:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];

    vector_ram_arbiter_if bus ();

    vector_ram_arbiter #(
        .READ_LATENCY (LAT),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM read data encodes the current cycle, so data checks also pin down return timing.
    assign bus.readData = {8{32'(cyc)}};

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_read(input logic owner);
        exp_t e;
        e.owner = owner;
        e.data  = {8{32'(cyc + LAT)}};
        exp_q.push_back(e);
    endtask

    task automatic set_a(input logic rd, input logic wr, input logic lock, input logic [13:0] addr,
                         input logic [31:0] be, input logic [255:0] wd);
        bus.a_rden = rd; bus.a_wren = wr; bus.a_lock = lock;
        bus.a_address = addr; bus.a_byteena = be; bus.a_writeData = wd;
    endtask

    task automatic set_b(input logic req, input logic we, input logic [13:0] addr,
                         input logic [31:0] be, input logic [255:0] wd);
        bus.b_req = req; bus.b_we = we;
        bus.b_address = addr; bus.b_byteena = be; bus.b_writeData = wd;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        set_a(0, 0, 0, 14'h0, 32'h0, '0);
        set_b(0, 0, 14'h0, 32'h0, '0);
        repeat (n) next_cycle();
    endtask

    // Checks the current cycle's combinational outputs, then advances one cycle.
    task automatic expect_ctl(input string name, input logic stall, input logic gnt,
                              input logic rd, input logic wr, input logic [13:0] ip,
                              input logic [31:0] be, input logic [255:0] wd);
        @(negedge clk);
        check({name, "/a_stall"},    256'(bus.a_stall),    256'(stall));
        check({name, "/b_gnt"},      256'(bus.b_gnt),      256'(gnt));
        check({name, "/rden"},       256'(bus.rden),       256'(rd));
        check({name, "/wren"},       256'(bus.wren),       256'(wr));
        check({name, "/ip_address"}, 256'(bus.ip_address), 256'(ip));
        check({name, "/byteena"},    256'(bus.byteena),    256'(be));
        check({name, "/writeData"},  bus.writeData,        wd);
        next_cycle();
    endtask

    task automatic expect_reset_zero(input string name);
        @(negedge clk);
        check({name, "/a_stall"},    256'(bus.a_stall),    256'd0);
        check({name, "/a_rvalid"},   256'(bus.a_rvalid),   256'd0);
        check({name, "/b_gnt"},      256'(bus.b_gnt),      256'd0);
        check({name, "/b_rvalid"},   256'(bus.b_rvalid),   256'd0);
        check({name, "/rden"},       256'(bus.rden),       256'd0);
        check({name, "/wren"},       256'(bus.wren),       256'd0);
        check({name, "/byteena"},    256'(bus.byteena),    256'd0);
        check({name, "/writeData"},  bus.writeData,        256'd0);
        check({name, "/ip_address"}, 256'(bus.ip_address), 256'd0);
        next_cycle();
    endtask

    // Scoreboard monitor: every rvalid must match the oldest outstanding read.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && (bus.a_rvalid || bus.b_rvalid)) begin
            if (bus.a_rvalid && bus.b_rvalid) begin
                checks++;
                failures++;
                $display("FAIL both_rvalid: a_rvalid=1 b_rvalid=1, required at most one");
            end else if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spurious_rvalid: a_rvalid=%0b b_rvalid=%0b, required no return",
                         bus.a_rvalid, bus.b_rvalid);
            end else begin
                e = exp_q.pop_front();
                check("rvalid_owner", 256'(bus.b_rvalid), 256'(e.owner));
                check("read_data", bus.b_rvalid ? bus.b_readData : bus.a_readData, e.data);
            end
        end
    end

    localparam logic [31:0]  A_BE = 32'hFFFF_FFFF;
    localparam logic [31:0]  B_BE = 32'h0000_FFFF;
    localparam logic [255:0] A_WD = {8{32'hA5A5_0001}};
    localparam logic [255:0] B_WD = {8{32'h5A5A_0002}};

    initial begin
        reset = 1'b1;
        set_a(0, 0, 0, 14'h0, 32'h0, '0);
        set_b(0, 0, 14'h0, 32'h0, '0);
        repeat (3) expect_reset_zero("reset_idle");
        reset = 1'b0;

        // 1: idle LSU, host read is granted in the same cycle
        set_b(1, 0, 14'h0010, B_BE, B_WD);
        push_read(1'b1);
        expect_ctl("host_read", 0, 1, 1, 0, 14'h0010, B_BE, B_WD);
        idle(LAT + 2);

        // 2: continuous LSU writes, host forced in after STARVE_LIMIT denied cycles (two rounds)
        set_a(0, 1, 0, 14'h0100, A_BE, A_WD);
        set_b(1, 1, 14'h0200, B_BE, B_WD);
        for (int r = 0; r < 2; r++) begin
            for (int i = 1; i <= LIMIT; i++) expect_ctl("starve_a", 0, 0, 0, 1, 14'h0100, A_BE, A_WD);
            expect_ctl("starve_force_b", 1, 1, 0, 1, 14'h0200, B_BE, B_WD);
        end
        idle(2);

        // 3: a_lock over cycles 8..10 defers the forced slot to the cycle after it drops
        set_a(0, 1, 0, 14'h0100, A_BE, A_WD);
        set_b(1, 1, 14'h0200, B_BE, B_WD);
        for (int i = 1; i <= 10; i++) begin
            bus.a_lock = (i >= 8);
            expect_ctl("lock_a", 0, 0, 0, 1, 14'h0100, A_BE, A_WD);
        end
        bus.a_lock = 1'b0;
        expect_ctl("lock_release_b", 1, 1, 0, 1, 14'h0200, B_BE, B_WD);
        expect_ctl("lock_after_a", 0, 0, 0, 1, 14'h0100, A_BE, A_WD);
        idle(2);

        // 4: alternating reads A, B, A return in order with no bubble
        set_a(1, 0, 0, 14'h0001, A_BE, '0);
        push_read(1'b0);
        expect_ctl("alt_read_a1", 0, 0, 1, 0, 14'h0001, A_BE, '0);
        set_a(0, 0, 0, 14'h0000, 32'h0, '0);
        set_b(1, 0, 14'h0002, B_BE, B_WD);
        push_read(1'b1);
        expect_ctl("alt_read_b", 0, 1, 1, 0, 14'h0002, B_BE, B_WD);
        set_b(0, 0, 14'h0000, 32'h0, '0);
        set_a(1, 0, 0, 14'h0003, A_BE, '0);
        push_read(1'b0);
        expect_ctl("alt_read_a3", 0, 0, 1, 0, 14'h0003, A_BE, '0);
        idle(LAT + 2);

        // 5: rden and wren together is a write with no read return
        set_a(1, 1, 0, 14'h0005, A_BE, A_WD);
        expect_ctl("rd_wr_both", 0, 0, 0, 1, 14'h0005, A_BE, A_WD);
        idle(LAT + 2);

        // 6: reset right after an LSU read drops it
        set_a(1, 0, 0, 14'h0007, A_BE, '0);
        expect_ctl("read_before_reset", 0, 0, 1, 0, 14'h0007, A_BE, '0);
        reset = 1'b1;
        set_b(1, 0, 14'h0009, B_BE, B_WD);
        repeat (2) expect_reset_zero("reset_midflight");
        reset = 1'b0;
        idle(LAT + 3);

        check("scoreboard_drained", 256'(exp_q.size()), 256'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
